// File: rtl/fetch_pkg.sv
// Shared constants for the fetch stage: instruction field layout, opcode map
// and default widths. The decoder imports the same opcode values.
package fetch_pkg;

    localparam int PC_W      = 8;
    localparam int INSTR_W   = 16;
    localparam int RAS_DEPTH = 8;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int TYP_MSB = 11;
    localparam int TYP_LSB = 10;
    localparam int FN2_MSB = 9;
    localparam int FN2_LSB = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_R    = 4'b0001;
    localparam logic [3:0] OP_FFT  = 4'b1011;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        NXT_HOLD   = 3'd0,
        NXT_SEQ    = 3'd1,
        NXT_JUMP   = 3'd2,
        NXT_BRANCH = 3'd3,
        NXT_CALL   = 3'd4,
        NXT_RET    = 3'd5,
        NXT_HALT   = 3'd6
    } next_sel_e;

endpackage

// File: rtl/fetch_unit_return_stack.sv
// Return-address stack: LIFO of PC values with full/empty status.
// Push when full and pop when empty are ignored here; the caller flags them.
module return_stack
    import fetch_pkg::*;
#(
    parameter int W     = PC_W,
    parameter int DEPTH = RAS_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int SP_W  = $clog2(DEPTH) + 1;
    localparam int IDX_W = SP_W - 1;

    logic [SP_W-1:0]  sp_q, sp_d;
    logic [SP_W-1:0]  sp_dec_s;
    logic [IDX_W-1:0] top_s;
    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];

    assign full     = (sp_q == SP_W'(DEPTH));
    assign empty    = (sp_q == {SP_W{1'b0}});
    assign sp_dec_s = sp_q - SP_W'(1);
    assign top_s    = sp_dec_s[IDX_W-1:0];
    assign pop_data = mem_q[top_s];

    // next stack pointer and storage contents
    always_comb begin
        sp_d  = sp_q;
        mem_d = mem_q;
        if (push && !full) begin
            mem_d[sp_q[IDX_W-1:0]] = push_data;
            sp_d = sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_d = sp_dec_s;
        end else begin
            sp_d = sp_q;
        end
    end

    // stack state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= {SP_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else begin
            sp_q  <= sp_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register, redirect mux and halt.
// IR fields are registered; a redirect or reset loads an all-zero bubble.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W_P      = PC_W,
    parameter int INSTR_W_P   = INSTR_W,
    parameter int RAS_DEPTH_P = RAS_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [PC_W_P-1:0]    imem_addr,
    input  logic [INSTR_W_P-1:0] imem_rdata,
    input  logic                 stall,
    input  logic                 jump_en,
    input  logic                 branch_en,
    input  logic                 branch_taken,
    input  logic                 call_en,
    input  logic                 ret_en,
    output logic [3:0]           opcode,
    output logic [1:0]           instr_type,
    output logic [1:0]           funct2,
    output logic [7:0]           imm8,
    output logic [PC_W_P-1:0]    ir_pc,
    output logic                 program_end,
    output logic                 ras_overflow,
    output logic                 ras_underflow
);

    logic [PC_W_P-1:0]    pc_q, pc_d;
    logic [PC_W_P-1:0]    ir_pc_q, ir_pc_d;
    logic [INSTR_W_P-1:0] ir_q, ir_d;
    logic                 valid_q, valid_d;
    logic                 pe_q, pe_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;

    logic                 push_s, pop_s, full_s, empty_s;
    logic [PC_W_P-1:0]    pop_data_s;
    logic [PC_W_P-1:0]    imm_pc_s;
    logic [PC_W_P-1:0]    branch_pc_s;
    logic [PC_W_P-1:0]    ret_addr_s;
    next_sel_e            sel_s;

    assign imm_pc_s    = PC_W_P'(ir_q[IMM_MSB:IMM_LSB]);
    assign branch_pc_s = ir_pc_q + PC_W_P'($signed(ir_q[IMM_MSB:IMM_LSB]));
    assign ret_addr_s  = ir_pc_q + PC_W_P'(1);

    // classify this edge; stall and halt freeze everything, and redirect
    // flags only count while the IR holds a real instruction
    always_comb begin
        sel_s = NXT_SEQ;
        if (stall || pe_q) begin
            sel_s = NXT_HOLD;
        end else if (valid_q && ir_q[OPC_MSB:OPC_LSB] == OP_HALT) begin
            sel_s = NXT_HALT;
        end else if (valid_q && jump_en) begin
            sel_s = NXT_JUMP;
        end else if (valid_q && branch_en && branch_taken) begin
            sel_s = NXT_BRANCH;
        end else if (valid_q && call_en) begin
            sel_s = NXT_CALL;
        end else if (valid_q && ret_en) begin
            sel_s = NXT_RET;
        end else begin
            sel_s = NXT_SEQ;
        end
    end

    // next-state for PC, IR, stack control and sticky flags
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        ir_pc_d = ir_pc_q;
        valid_d = valid_q;
        pe_d    = pe_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        case (sel_s)
            NXT_SEQ: begin
                ir_d    = imem_rdata;
                valid_d = 1'b1;
                ir_pc_d = pc_q;
                pc_d    = pc_q + PC_W_P'(1);
            end
            NXT_HALT: begin
                pe_d = 1'b1;
            end
            NXT_JUMP: begin
                pc_d    = imm_pc_s;
                ir_d    = {INSTR_W_P{1'b0}};
                valid_d = 1'b0;
            end
            NXT_BRANCH: begin
                pc_d    = branch_pc_s;
                ir_d    = {INSTR_W_P{1'b0}};
                valid_d = 1'b0;
            end
            NXT_CALL: begin
                // a call with a full stack still jumps; only the return is lost
                if (full_s) begin
                    ovf_d = 1'b1;
                end else begin
                    push_s = 1'b1;
                end
                pc_d    = imm_pc_s;
                ir_d    = {INSTR_W_P{1'b0}};
                valid_d = 1'b0;
            end
            NXT_RET: begin
                if (empty_s) begin
                    unf_d = 1'b1;
                    pe_d  = 1'b1;
                end else begin
                    pop_s   = 1'b1;
                    pc_d    = pop_data_s;
                    ir_d    = {INSTR_W_P{1'b0}};
                    valid_d = 1'b0;
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // fetch state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= {PC_W_P{1'b0}};
            ir_q    <= {INSTR_W_P{1'b0}};
            ir_pc_q <= {PC_W_P{1'b0}};
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
            valid_q <= valid_d;
            pe_q    <= pe_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    return_stack #(
        .W     (PC_W_P),
        .DEPTH (RAS_DEPTH_P)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (ret_addr_s),
        .pop_data  (pop_data_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign imem_addr     = pc_q;
    assign opcode        = ir_q[OPC_MSB:OPC_LSB];
    assign instr_type    = ir_q[TYP_MSB:TYP_LSB];
    assign funct2        = ir_q[FN2_MSB:FN2_LSB];
    assign imm8          = ir_q[IMM_MSB:IMM_LSB];
    assign ir_pc         = ir_pc_q;
    assign program_end   = pe_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations plus a randomized run against a queue-based reference model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        stall, jump_en, branch_en, branch_taken, call_en, ret_en;
    logic [3:0]  opcode;
    logic [1:0]  instr_type, funct2;
    logic [7:0]  imm8, ir_pc;
    logic        program_end, ras_overflow, ras_underflow;

    logic [15:0] rom [256];
    assign imem_rdata = rom[imem_addr];

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [7:0]  m_pc;
    logic [15:0] m_ir;
    logic        m_valid;
    logic [7:0]  m_irpc;
    logic        m_pe, m_ovf, m_unf;
    logic [7:0]  m_ras [$];

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .jump_en       (jump_en),
        .branch_en     (branch_en),
        .branch_taken  (branch_taken),
        .call_en       (call_en),
        .ret_en        (ret_en),
        .opcode        (opcode),
        .instr_type    (instr_type),
        .funct2        (funct2),
        .imm8          (imm8),
        .ir_pc         (ir_pc),
        .program_end   (program_end),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00; m_ir = 16'h0000; m_valid = 1'b0; m_irpc = 8'h00;
        m_pe = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        m_ras.delete();
    endtask

    task automatic model_bubble();
        m_ir    = 16'h0000;
        m_valid = 1'b0;
    endtask

    task automatic model_edge(input bit s, j, b, bt, c, r);
        if (s || m_pe) return;
        if (m_valid && m_ir[15:12] == 4'hF) begin
            m_pe = 1'b1;
        end else if (m_valid && j) begin
            m_pc = m_ir[7:0];
            model_bubble();
        end else if (m_valid && b && bt) begin
            m_pc = 8'((int'(m_irpc) + int'($signed(m_ir[7:0]))) & 255);
            model_bubble();
        end else if (m_valid && c) begin
            if (m_ras.size() >= 8) m_ovf = 1'b1;
            else m_ras.push_back(8'(m_irpc + 8'd1));
            m_pc = m_ir[7:0];
            model_bubble();
        end else if (m_valid && r) begin
            if (m_ras.size() == 0) begin
                m_unf = 1'b1;
                m_pe  = 1'b1;
            end else begin
                m_pc = m_ras.pop_back();
                model_bubble();
            end
        end else begin
            m_ir    = rom[m_pc];
            m_valid = 1'b1;
            m_irpc  = m_pc;
            m_pc    = 8'(m_pc + 8'd1);
        end
    endtask

    task automatic cmp_model();
        logic [15:0] e;
        e = m_valid ? m_ir : 16'h0000;
        chk("imem_addr", imem_addr, m_pc);
        chk("opcode", opcode, e[15:12]);
        chk("instr_type", instr_type, e[11:10]);
        chk("funct2", funct2, e[9:8]);
        chk("imm8", imm8, e[7:0]);
        if (m_valid) chk("ir_pc", ir_pc, m_irpc);
        chk("program_end", program_end, m_pe);
        chk("ras_overflow", ras_overflow, m_ovf);
        chk("ras_underflow", ras_underflow, m_unf);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_opcode"}, opcode, 32'h0);
        chk({tag, "_fields"}, {instr_type, funct2, imm8, ir_pc}, 32'h0);
        chk({tag, "_flags"}, {program_end, ras_overflow, ras_underflow}, 32'h0);
    endtask

    task automatic step(input bit s, j, b, bt, c, r);
        stall = s; jump_en = j; branch_en = b; branch_taken = bt; call_en = c; ret_en = r;
        @(posedge clk);
        model_edge(s, j, b, bt, c, r);
        @(negedge clk);
        cmp_model();
    endtask

    task automatic nx();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        stall = 1'b0; jump_en = 1'b0; branch_en = 1'b0;
        branch_taken = 1'b0; call_en = 1'b0; ret_en = 1'b0;
        #2;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cmp_model();
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 256; i++) rom[i] = v;
    endtask

    initial begin
        int pe_cnt;
        int k;
        bit s, bt;
        logic [3:0] op;
        rst_n = 1'b0;
        stall = 1'b0; jump_en = 1'b0; branch_en = 1'b0;
        branch_taken = 1'b0; call_en = 1'b0; ret_en = 1'b0;
        model_reset();

        // sequential fetch after reset
        fill(16'h1000);
        rom[1] = 16'h2000;
        rom[2] = 16'h1100;
        do_reset();
        chk("seq0_addr", imem_addr, 32'h00);
        nx(); chk("seq1_addr", imem_addr, 32'h01); chk("seq1_op", opcode, 32'h1);
        nx(); chk("seq2_addr", imem_addr, 32'h02); chk("seq2_op", opcode, 32'h2);
        nx(); chk("seq3_addr", imem_addr, 32'h03); chk("seq3_op", opcode, 32'h1);
        chk("seq3_funct2", funct2, 32'h1);

        // jump to 0x40 with one bubble
        fill(16'h1000);
        rom[2] = 16'h3040;
        rom[8'h40] = 16'h7ABC;
        do_reset();
        nx(); nx(); nx();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("jump_addr", imem_addr, 32'h40); chk("jump_bubble", opcode, 32'h0);
        nx();
        chk("jump_op", opcode, 32'h7); chk("jump_imm", imm8, 32'hBC); chk("jump_irpc", ir_pc, 32'h40);

        // branch taken backwards, then not taken
        fill(16'h1000);
        rom[0] = 16'h3010;
        rom[8'h10] = 16'h40FC;
        for (int t = 0; t < 2; t++) begin
            do_reset();
            nx();
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            nx();
            chk("br_pre_addr", imem_addr, 32'h11);
            step(1'b0, 1'b0, 1'b1, t == 0, 1'b0, 1'b0);
            chk("br_addr", imem_addr, (t == 0) ? 32'h0C : 32'h12);
        end

        // call 0x05 -> 0x20, return to 0x06
        fill(16'h1000);
        rom[0] = 16'h3005;
        rom[5] = 16'h5020;
        rom[8'h20] = 16'h6000;
        do_reset();
        nx();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        nx();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("call_addr", imem_addr, 32'h20);
        nx();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ret_addr", imem_addr, 32'h06);
        nx();
        chk("ret_irpc", ir_pc, 32'h06);

        // nine nested calls overflow an eight-entry stack
        rom[8'h20] = 16'h5020;
        rom[0] = 16'h3020;
        do_reset();
        nx();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            nx();
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("ovf_seq", ras_overflow, (i >= 8) ? 32'h1 : 32'h0);
        end

        // return with an empty stack
        fill(16'h1000);
        do_reset();
        nx();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("unf_flag", ras_underflow, 32'h1); chk("unf_end", program_end, 32'h1);
        nx(); nx();
        chk("unf_hold", imem_addr, 32'h01);

        // stall holds PC and IR
        rom[0] = 16'h9000;
        do_reset();
        nx();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("stall_addr", imem_addr, 32'h01); chk("stall_op", opcode, 32'h9);
        end
        nx();
        chk("stall_rel_addr", imem_addr, 32'h02); chk("stall_rel_op", opcode, 32'h1);

        // HALT at address 4
        fill(16'h1000);
        rom[4] = 16'hF000;
        do_reset();
        for (int i = 0; i < 5; i++) nx();
        chk("halt_op", opcode, 32'hF);
        nx();
        chk("halt_end", program_end, 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("halt_addr", imem_addr, 32'h05);
        end

        // asynchronous reset while stalled
        fill(16'h1000);
        rom[0] = 16'h2000;
        do_reset();
        nx(); nx();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("async");
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        model_reset();
        cmp_model();
        nx();
        chk("async_addr", imem_addr, 32'h01); chk("async_op", opcode, 32'h2);

        // randomized run against the model
        for (int i = 0; i < 256; i++) begin
            op = ($urandom_range(0, 63) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            rom[i] = {op, 12'($urandom)};
        end
        do_reset();
        pe_cnt = 0;
        for (int n = 0; n < 4000; n++) begin
            s  = ($urandom_range(0, 9) == 0);
            bt = ($urandom_range(0, 1) == 1);
            k  = $urandom_range(0, 19);
            step(s, k inside {[12:13]}, k inside {[14:15]}, bt, k inside {[16:18]}, k == 19);
            pe_cnt = m_pe ? pe_cnt + 1 : 0;
            if (pe_cnt > 2) begin
                do_reset();
                pe_cnt = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
